data_array_fill: RTL and testbench
==================================

DATA_ARRAY_FILL -- requirements
Module: data_array_fill

Interface
REQ-001 Parameter s_index, default 3, set index width; num_sets = 2**s_index.
REQ-002 Parameter s_offset, default 5, byte-offset width; s_mask = 2**s_offset bytes per line, s_line = 8*s_mask bits.
REQ-003 Parameter num_ways, default 2, ways per set; s_way = $clog2(num_ways), minimum 1.
REQ-004 Parameter s_beat, default 64, fill beat width in bits; num_beats = s_line/s_beat, a power of two and at least 2.
REQ-005 clk  input  1  single clock, all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 read  input  1  read strobe; captures all ways of rindex.
REQ-008 rindex  input  s_index  read set.
REQ-009 dataout  output  num_ways*s_line  registered read data, way w at bits [w*s_line +: s_line].
REQ-010 write_en  input  s_mask  CPU byte write mask.
REQ-011 windex  input  s_index  CPU write set.
REQ-012 wway  input  s_way  CPU write way.
REQ-013 datain  input  s_line  CPU write data.
REQ-014 fill_start  input  1  request line fill.
REQ-015 fill_index  input  s_index  fill set, sampled with fill_start.
REQ-016 fill_way  input  s_way  fill way, sampled with fill_start.
REQ-017 beat_valid  input  1  fill beat present.
REQ-018 beat_data  input  s_beat  fill beat payload.
REQ-019 beat_ready  output  1  block accepts a beat.
REQ-020 fill_busy  output  1  fill in progress.
REQ-021 fill_done  output  1  one-cycle pulse on line commit.

Function
REQ-022 Read latency SHALL be 1 cycle; read=1 at an edge loads dataout with all ways of rindex; read=0 holds dataout.
REQ-023 CPU write SHALL update byte i of line (windex, wway) when write_en[i]=1; other bytes unchanged.
REQ-024 Fill FSM SHALL have states IDLE, FILL, COMMIT.
REQ-025 IDLE: fill_start=1 latches fill_index/fill_way, clears beat counter, goes to FILL.
REQ-026 FILL: beat_ready=1; each beat_valid&beat_ready stores beat_data into staging bits [cnt*s_beat +: s_beat] and increments cnt; accepting beat num_beats-1 goes to COMMIT.
REQ-027 beat_valid=0 in FILL SHALL stall the counter with no timeout.
REQ-028 COMMIT: whole staging line written to latched set/way; fill_done=1 for this cycle only; next state IDLE.
REQ-029 beat_ready SHALL be 0 in IDLE and COMMIT; fill_busy=1 in FILL and COMMIT.
REQ-030 fill_start while fill_busy=1 SHALL be ignored.
REQ-031 CPU write to the fill target in the COMMIT cycle: bytes with write_en=1 take CPU data, others take staging data.
REQ-032 CPU writes to the fill target during FILL SHALL be overwritten by the commit.
REQ-033 CPU writes and commits to other lines SHALL proceed in the same cycle independently.

Reset
REQ-034 rst=1 SHALL immediately force: FSM IDLE, cnt 0, beat_ready 0, fill_busy 0, fill_done 0, dataout all-zero, array contents all-zero.
REQ-035 Reset mid-fill SHALL abandon the fill with no commit and no fill_done.

Configuration
REQ-036 Macro DATA_ARRAY_BYPASS_EN defined: a read in the same cycle as a CPU write or commit to the same set SHALL return, per way and byte, the data being written that cycle.
REQ-037 DATA_ARRAY_BYPASS_EN undefined: such a read SHALL return the pre-write array contents; the new data is visible to the next read.

Verification
REQ-038 Reset, then read set 0 -> dataout = 0 next cycle; beat_ready=0, fill_busy=0.
REQ-039 fill_start set 5 way 1, four 64-bit beats 0x11..,0x22..,0x33..,0x44.. with a beat_valid gap after beat 1 -> fill_done pulse 1 cycle after beat 4; read set 5 -> way 1 = {0x44..,0x33..,0x22..,0x11..}, way 0 unchanged.
REQ-040 COMMIT cycle with CPU write_en=0x0000_0001, datain byte0=0xAB to same set/way -> line byte0 = 0xAB, rest fill data.
REQ-041 rst asserted after beat 2 -> fill_busy drops immediately, no fill_done, target line stays 0.
REQ-042 Same-cycle write byte3=0x5A and read of set 2 -> with DATA_ARRAY_BYPASS_EN byte3=0x5A; without, old value, then 0x5A on next read.
REQ-043 fill_start during FILL -> ignored; latched index/way unchanged, one fill_done only.

Source files
------------

// File: rtl/data_array_fill.sv
// data_array_fill: set-associative line data array with CPU byte writes and a beat-wise line fill engine
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset clears FSM, staging, dataout and the whole array
//   read, rindex      read strobe/set; dataout loads all ways of rindex one cycle later, holds otherwise
//   dataout           num_ways*s_line bits, way w at [w*s_line +: s_line]
//   write_en, windex,
//   wway, datain      CPU byte-masked write to line (windex, wway)
//   fill_start,
//   fill_index,
//   fill_way          start a line fill into (fill_index, fill_way) when idle
//   beat_valid,
//   beat_data,
//   beat_ready        beat handshake; beats land in staging in ascending order
//   fill_busy         high in FILL and COMMIT
//   fill_done         one-cycle pulse during the COMMIT cycle
//
// Configuration:
//   DATA_ARRAY_BYPASS_EN  when defined, a read returns the data being written to its set that same
//                         cycle; otherwise it returns the pre-write contents.
module data_array_fill #(
    parameter int s_index  = 3,
    parameter int s_offset = 5,
    parameter int num_ways = 2,
    parameter int s_beat   = 64,
    localparam int num_sets  = 2**s_index,
    localparam int s_mask    = 2**s_offset,
    localparam int s_line    = 8*s_mask,
    localparam int s_way     = num_ways > 1 ? $clog2(num_ways) : 1,
    localparam int num_beats = s_line/s_beat,
    localparam int s_cnt     = $clog2(num_beats)
)(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         read,
    input  logic [s_index-1:0]           rindex,
    output logic [num_ways*s_line-1:0]   dataout,
    input  logic [s_mask-1:0]            write_en,
    input  logic [s_index-1:0]           windex,
    input  logic [s_way-1:0]             wway,
    input  logic [s_line-1:0]            datain,
    input  logic                         fill_start,
    input  logic [s_index-1:0]           fill_index,
    input  logic [s_way-1:0]             fill_way,
    input  logic                         beat_valid,
    input  logic [s_beat-1:0]            beat_data,
    output logic                         beat_ready,
    output logic                         fill_busy,
    output logic                         fill_done
);
    typedef enum logic [1:0] {IDLE, FILL, COMMIT} state_t;

    state_t                        r_state;
    logic [s_cnt-1:0]              r_cnt;
    logic [s_index-1:0]            r_idx;
    logic [s_way-1:0]              r_way;
    logic [s_line-1:0]             r_stage;
    logic                          r_beat_ready;
    logic                          r_fill_busy;
    logic                          r_fill_done;
    logic [s_line-1:0]             r_mem [num_sets][num_ways];
    logic [num_ways*s_line-1:0]    r_dataout;

    logic [s_line-1:0]             w_bm;
    logic [s_line-1:0]             w_next [num_sets][num_ways];
    logic [num_ways*s_line-1:0]    w_rd;

    assign beat_ready = r_beat_ready;
    assign fill_busy  = r_fill_busy;
    assign fill_done  = r_fill_done;
    assign dataout    = r_dataout;

    always_comb begin
        w_bm = '0;
        for (int b = 0; b < s_mask; b++)
            w_bm[8*b +: 8] = {8{write_en[b]}};
    end

    // Next value of every line: the commit supplies the base line, then CPU-enabled bytes override it,
    // so a CPU write in the commit cycle wins per byte and earlier FILL-time writes are overwritten.
    for (genvar s = 0; s < num_sets; s++) begin : g_set
        for (genvar w = 0; w < num_ways; w++) begin : g_way
            logic              w_commit_hit;
            logic              w_cpu_hit;
            logic [s_line-1:0] w_base;
            assign w_commit_hit  = r_state == COMMIT && r_idx == s_index'(s) && r_way == s_way'(w);
            assign w_cpu_hit     = windex == s_index'(s) && wway == s_way'(w);
            assign w_base        = w_commit_hit ? r_stage : r_mem[s][w];
            assign w_next[s][w]  = w_cpu_hit ? (datain & w_bm) | (w_base & ~w_bm) : w_base;
        end
    end

    always_comb begin
        w_rd = '0;
        for (int w = 0; w < num_ways; w++)
`ifdef DATA_ARRAY_BYPASS_EN
            w_rd[w*s_line +: s_line] = w_next[rindex][w];
`else
            w_rd[w*s_line +: s_line] = r_mem[rindex][w];
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < num_sets; s++)
                for (int w = 0; w < num_ways; w++)
                    r_mem[s][w] <= '0;
        end else begin
            for (int s = 0; s < num_sets; s++)
                for (int w = 0; w < num_ways; w++)
                    r_mem[s][w] <= w_next[s][w];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_dataout <= '0;
        else if (read)
            r_dataout <= w_rd;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_way        <= '0;
            r_stage      <= '0;
            r_beat_ready <= 1'b0;
            r_fill_busy  <= 1'b0;
            r_fill_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_fill_done <= 1'b0;
                    if (fill_start) begin
                        r_idx        <= fill_index;
                        r_way        <= fill_way;
                        r_cnt        <= '0;
                        r_state      <= FILL;
                        r_beat_ready <= 1'b1;
                        r_fill_busy  <= 1'b1;
                    end
                end
                FILL: begin
                    if (beat_valid && r_beat_ready) begin
                        r_stage[r_cnt*s_beat +: s_beat] <= beat_data;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == s_cnt'(num_beats-1)) begin
                            r_state      <= COMMIT;
                            r_beat_ready <= 1'b0;
                            r_fill_done  <= 1'b1;
                        end
                    end
                end
                COMMIT: begin
                    r_state     <= IDLE;
                    r_fill_busy <= 1'b0;
                    r_fill_done <= 1'b0;
                end
                default: begin
                    r_state      <= IDLE;
                    r_beat_ready <= 1'b0;
                    r_fill_busy  <= 1'b0;
                    r_fill_done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_data_array_fill.sv
// tb_data_array_fill: directed self-checking bench for data_array_fill at default parameters
module tb_data_array_fill;
    logic         clk = 0;
    logic         rst = 0;
    logic         read = 0;
    logic [2:0]   rindex = 0;
    logic [511:0] dataout;
    logic [31:0]  write_en = 0;
    logic [2:0]   windex = 0;
    logic [0:0]   wway = 0;
    logic [255:0] datain = 0;
    logic         fill_start = 0;
    logic [2:0]   fill_index = 0;
    logic [0:0]   fill_way = 0;
    logic         beat_valid = 0;
    logic [63:0]  beat_data = 0;
    logic         beat_ready;
    logic         fill_busy;
    logic         fill_done;

    int checks = 0;
    int errors = 0;

    data_array_fill dut (
        .clk(clk), .rst(rst), .read(read), .rindex(rindex), .dataout(dataout),
        .write_en(write_en), .windex(windex), .wway(wway), .datain(datain),
        .fill_start(fill_start), .fill_index(fill_index), .fill_way(fill_way),
        .beat_valid(beat_valid), .beat_data(beat_data), .beat_ready(beat_ready),
        .fill_busy(fill_busy), .fill_done(fill_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic flags(input string tag, input logic r, input logic b, input logic d);
        chk({tag, "_ready"}, {511'd0, beat_ready}, {511'd0, r});
        chk({tag, "_busy"},  {511'd0, fill_busy},  {511'd0, b});
        chk({tag, "_done"},  {511'd0, fill_done},  {511'd0, d});
    endtask

    logic [255:0] p0, l5, l3, l1, exp_byte3_now;

    initial begin
        p0 = {8{32'hCAFE_F00D}};
        l5 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        l3 = {64'hD4D4_D4D4_D4D4_D4D4, 64'hC3C3_C3C3_C3C3_C3C3, 64'hB2B2_B2B2_B2B2_B2B2, 64'hA1A1_A1A1_A1A1_A1AB};
        l1 = {32{8'h77}};
        // async reset takes effect without a clock edge
        #1 rst = 1;
        #1;
        flags("rst_async", 0, 0, 0);
        chk("rst_dataout", dataout, '0);
        tick();
        rst = 0;
        // read set 0 after reset
        read = 1; rindex = 0;
        tick();
        chk("rd0_after_rst", dataout, '0);
        flags("idle", 0, 0, 0);
        // preload set 5 way 0
        read = 0;
        write_en = '1; windex = 5; wway = 0; datain = p0;
        tick();
        write_en = 0;
        // fill set 5 way 1 with a gap after beat 1 and a stray fill_start during FILL
        fill_start = 1; fill_index = 5; fill_way = 1;
        tick();
        flags("fill_entry", 1, 1, 0);
        fill_start = 0;
        beat_valid = 1; beat_data = 64'h1111_1111_1111_1111;
        tick();
        beat_valid = 0; fill_start = 1; fill_index = 2; fill_way = 0;
        tick();
        flags("fill_gap", 1, 1, 0);
        fill_start = 0;
        beat_valid = 1; beat_data = 64'h2222_2222_2222_2222;
        tick();
        beat_data = 64'h3333_3333_3333_3333;
        tick();
        beat_data = 64'h4444_4444_4444_4444;
        tick();
        flags("commit", 0, 1, 1);
        beat_valid = 0;
        // independent CPU write to another line in the commit cycle
        write_en = '1; windex = 1; wway = 1; datain = l1;
        tick();
        write_en = 0;
        flags("after_commit", 0, 0, 0);
        tick();
        flags("no_second_done", 0, 0, 0);
        read = 1; rindex = 5;
        tick();
        chk("set5_way1_fill", dataout[511:256], l5);
        chk("set5_way0_kept", dataout[255:0], p0);
        rindex = 2;
        tick();
        chk("set2_untouched", dataout, '0);
        rindex = 1;
        tick();
        chk("set1_way1_cpu", dataout[511:256], l1);
        read = 0;
        // fill set 3 way 0; CPU write during FILL is overwritten, byte0 write in COMMIT wins
        fill_start = 1; fill_index = 3; fill_way = 0;
        tick();
        fill_start = 0;
        beat_valid = 1; beat_data = 64'hA1A1_A1A1_A1A1_A1A1;
        tick();
        beat_valid = 0; write_en = '1; windex = 3; wway = 0; datain = '1;
        tick();
        write_en = 0;
        beat_valid = 1; beat_data = 64'hB2B2_B2B2_B2B2_B2B2;
        tick();
        beat_data = 64'hC3C3_C3C3_C3C3_C3C3;
        tick();
        beat_data = 64'hD4D4_D4D4_D4D4_D4D4;
        tick();
        beat_valid = 0;
        chk("commit2_done", {511'd0, fill_done}, {511'd0, 1'b1});
        write_en = 32'h0000_0001; windex = 3; wway = 0; datain = 256'hAB;
        tick();
        write_en = 0;
        read = 1; rindex = 3;
        tick();
        chk("set3_merge", dataout[255:0], l3);
        read = 0;
        // reset after beat 2 abandons the fill
        fill_start = 1; fill_index = 6; fill_way = 1;
        tick();
        fill_start = 0;
        beat_valid = 1; beat_data = 64'h5555_5555_5555_5555;
        tick();
        beat_data = 64'h6666_6666_6666_6666;
        tick();
        beat_valid = 0;
        rst = 1;
        #1;
        flags("rst_midfill", 0, 0, 0);
        tick();
        rst = 0;
        tick();
        flags("post_rst_idle", 0, 0, 0);
        read = 1; rindex = 6;
        tick();
        chk("set6_zero", dataout, '0);
        // same-cycle write and read of set 2
        write_en = 32'h0000_0008; windex = 2; wway = 0; datain = 256'h5A00_0000;
        rindex = 2;
        tick();
        write_en = 0;
`ifdef DATA_ARRAY_BYPASS_EN
        exp_byte3_now = 256'h5A00_0000;
`else
        exp_byte3_now = '0;
`endif
        chk("same_cycle_rd", dataout[255:0], exp_byte3_now);
        tick();
        chk("next_rd", dataout[255:0], 256'h5A00_0000);
        // read=0 holds dataout
        read = 0; rindex = 0;
        tick();
        chk("rd_hold", dataout[255:0], 256'h5A00_0000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
